muldiv_ctrl: RTL

- Sequencing controller for the shared multiply/divide resources of the MIPS core (multiplier and restoring divider).
- Accepts one MULT or DIV request from the execute stage and holds the operands stable at the selected unit for its full run.
- Fires a one-cycle start, counts the fixed latency, then captures the result into architectural HI/LO.
- Drives busy so the pipeline stalls while an operation is in flight; raises a divide-by-zero exception without starting the divider.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and default latencies for the multiply/divide sequencing controller.
package muldiv_pkg;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_MULT = 2'd1,
        RUN_DIV  = 2'd2,
        CAPTURE  = 2'd3
    } state_t;

    localparam int MULT_LAT_DEF = 33;
    localparam int DIV_LAT_DEF  = 34;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the shared multiplier and restoring divider: holds operands,
// fires start, counts latency, captures HI/LO. Optional MTHI/MTLO ports under MULDIV_MTHILO_EN.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic        op_sel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mult_start,
    output logic        div_start,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
`ifdef MULDIV_MTHILO_EN
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0_exc
);

    state_t           state, state_nxt;
    op_t              op, op_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      a_nxt, b_nxt, hi_nxt, lo_nxt;
    logic             mstart_nxt, dstart_nxt, done_nxt, div0_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_MULT;
            cnt        <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            hi         <= '0;
            lo         <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div0_exc   <= 1'b0;
        end else begin
            state      <= state_nxt;
            op         <= op_nxt;
            cnt        <= cnt_nxt;
            unit_a     <= a_nxt;
            unit_b     <= b_nxt;
            hi         <= hi_nxt;
            lo         <= lo_nxt;
            mult_start <= mstart_nxt;
            div_start  <= dstart_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= done_nxt;
            div0_exc   <= div0_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op;
        cnt_nxt    = cnt;
        a_nxt      = unit_a;
        b_nxt      = unit_b;
        hi_nxt     = hi;
        lo_nxt     = lo;
        mstart_nxt = 1'b0;
        dstart_nxt = 1'b0;
        done_nxt   = 1'b0;
        div0_nxt   = 1'b0;

        case (state)
            IDLE: begin
`ifdef MULDIV_MTHILO_EN
                // An op accepted in the same cycle will overwrite these at its capture.
                if (wr_hi) hi_nxt = wr_data;
                if (wr_lo) lo_nxt = wr_data;
`endif
                if (op_valid) begin
                    a_nxt = src_a;
                    b_nxt = src_b;
                    if (op_sel == OP_DIV) begin
                        if (src_b == 32'd0) begin
                            div0_nxt = 1'b1;
                        end else begin
                            state_nxt  = RUN_DIV;
                            op_nxt     = OP_DIV;
                            dstart_nxt = 1'b1;
                            cnt_nxt    = CNT_W'(DIV_LAT - 1);
                        end
                    end else begin
                        state_nxt  = RUN_MULT;
                        op_nxt     = OP_MULT;
                        mstart_nxt = 1'b1;
                        cnt_nxt    = CNT_W'(MULT_LAT - 1);
                    end
                end
            end
            RUN_MULT, RUN_DIV: begin
                if (cnt == '0) state_nxt = CAPTURE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            CAPTURE: begin
                // Operands stay held here; the divider fixes its remainder sign from A now.
                if (op == OP_DIV) begin
                    hi_nxt = div_hi;
                    lo_nxt = div_lo;
                end else begin
                    hi_nxt = mult_hi;
                    lo_nxt = mult_lo;
                end
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
